micro_arp_requester: RTL and testbench
======================================

MICRO_ARP_REQUESTER -- requirements
Module: micro_arp_requester

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h02ABCD000102, the source MAC placed in the Ethernet header and the ARP SHA field.
REQ-002 SHALL have parameter LOCAL_IP, default 32'h0A000014, the ARP SPA field and the expected TPA of replies.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, the number of WAIT cycles allowed per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, the number of retransmissions after the first attempt.
REQ-005 SHALL have ports clk (in, 1, the single clock) and reset_n (in, 1, asynchronous active-low reset).
REQ-006 SHALL have request ports req_valid (in, 1), req_ready (out, 1) and req_ip (in, 32, the target IPv4 address).
REQ-007 SHALL have result ports resp_valid (out, 1, one-cycle pulse), resp_mac (out, 48), resp_ip (out, 32) and resp_error (out, 1, resolution timed out).
REQ-008 SHALL have a TX Avalon-ST source: tx_data (out, 256), tx_valid (out, 1), tx_ready (in, 1), tx_startofpacket (out, 1), tx_endofpacket (out, 1), tx_empty (out, 5).
REQ-009 SHALL have an RX Avalon-ST sink: rx_data (in, 256), rx_valid (in, 1), rx_ready (out, 1), rx_startofpacket (in, 1), rx_endofpacket (in, 1), rx_empty (in, 5).

Function
REQ-010 SHALL place byte 0 of each beat on data[255:248] (network order) on both streams.
REQ-011 SHALL accept a request when req_valid and req_ready are both high; req_ready SHALL be high only in IDLE.
REQ-012 SHALL latch req_ip on acceptance and move to TX_W0.
REQ-013 SHALL use main FSM states IDLE, TX_W0, TX_W1, WAIT and DONE.
REQ-014 SHALL drive beat 0 in TX_W0 with sop=1, eop=0, empty=0, carrying: dst FFFFFFFFFFFF, src LOCAL_MAC, type 0806, htype 0001, ptype 0800, hlen 06, plen 04, oper 0001, SHA LOCAL_MAC, SPA LOCAL_IP.
REQ-015 SHALL drive beat 1 in TX_W1 with sop=0, eop=1, empty=22; data[255:208] SHALL be THA 0, data[207:176] SHALL be TPA req_ip, and data[175:0] SHALL be 0.
REQ-016 SHALL hold tx_valid high and all tx outputs stable while tx_ready is low; a beat SHALL advance only on tx_valid and tx_ready.
REQ-017 SHALL enter WAIT after beat 1 is accepted, clearing the timeout counter.
REQ-018 SHALL drive rx_ready constantly high (never backpressure).
REQ-019 SHALL match a reply when all of these hold: beat 0 has sop, ethertype 0806 and oper 0002; SPA equals the latched IP; beat 1 THA equals LOCAL_MAC.
REQ-020 SHALL evaluate the match at the beat-1 handshake; the captured SHA (beat 0 bytes 22-27) SHALL become resp_mac.
REQ-021 SHALL discard frames shorter or longer than the match criteria require, skipping beats until eop.
REQ-022 SHALL restart parsing when sop arrives mid-frame.
REQ-023 SHALL honour a match only in WAIT; matches arriving in other states SHALL be ignored.
REQ-024 SHALL, on a match in WAIT, go to DONE and pulse resp_valid for one cycle with resp_error=0, resp_ip = latched IP and resp_mac = SHA; DONE SHALL then return to IDLE.
REQ-025 SHALL, when the WAIT counter reaches TIMEOUT_CYCLES-1 and retries are below MAX_RETRIES, increment the retry count and return to TX_W0.
REQ-026 SHALL, when retries are exhausted, pulse resp_valid with resp_error=1, resp_mac=0 and resp_ip = latched IP.
REQ-027 SHALL give a match priority over a timeout in the same cycle.
REQ-028 SHALL size the counters at $clog2(TIMEOUT_CYCLES+1) and $clog2(MAX_RETRIES+1) bits, with no wrap-around.

Reset
REQ-029 SHALL, on reset_n low, immediately force FSMs to IDLE and clear the counters.
REQ-030 SHALL, on reset_n low, drive tx_valid, tx_startofpacket, tx_endofpacket, resp_valid and resp_error to 0, tx_empty to 0, and tx_data, resp_mac and resp_ip to 0.
REQ-031 SHALL hold rx_ready at 1 while in reset and after reset.
REQ-032 SHALL abandon any in-flight request on reset mid-operation, without emitting resp_valid.

Structure
REQ-033 SHALL take the following from package micro_arp_pkg: ETHERTYPE_ARP, ARP_OPER_REQ/REPLY, HTYPE/PTYPE constants, byte-offset constants, the tx FSM enum and the rx parser enum.
REQ-034 SHALL contain one sub-module, micro_arp_rx_parser (states RX_W0, RX_W1, RX_DROP), which outputs match_pulse and sha.

Verification
REQ-035 Request 0A00000A with tx_ready=1 -> 2 beats; beat 0 = FFFFFFFFFFFF02ABCD00010208060001080006040001 02ABCD0001020A000014; beat 1 top 80 bits = 0000000000000A00000A, empty 22.
REQ-036 Reply with SHA 3CFDFEA67500, SPA 0A00000A, THA 02ABCD000102, sent 10 cycles into WAIT -> resp_valid pulse, resp_mac=3CFDFEA67500, resp_error=0.
REQ-037 No reply, TIMEOUT_CYCLES=20, MAX_RETRIES=2 -> exactly 3 requests transmitted, then resp_error=1.
REQ-038 tx_ready toggled 1010 during transmission -> data is held stable, beats are not duplicated, and the frame is identical to REQ-035.
REQ-039 Reply with wrong SPA (0A00000B), then a 3-beat non-ARP frame, then a correct reply -> only the correct reply produces resp_valid.
REQ-040 reset_n asserted in WAIT -> outputs reset immediately, no resp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/micro_arp_pkg.sv
// Shared ARP constants, frame byte offsets and FSM state encodings
// for the ARP requester and its reply parser.
package micro_arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
  localparam logic [15:0] HTYPE_ETH      = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  HLEN_ETH       = 8'h06;
  localparam logic [7:0]  PLEN_IPV4      = 8'h04;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  // 42-byte request: beat 1 carries 10 bytes, the rest of the 32-byte beat is empty
  localparam logic [4:0]  TX_W1_EMPTY     = 5'd22;
  localparam logic [4:0]  RX_W1_MAX_EMPTY = 5'd26;

  localparam int OFF_TYPE = 12;
  localparam int OFF_OPER = 20;
  localparam int OFF_SHA  = 22;
  localparam int OFF_SPA  = 28;
  localparam int OFF_THA  = 0;

  function automatic int msb_of(input int byte_off);
    return 255 - 8 * byte_off;
  endfunction

  localparam int BIT_TYPE = msb_of(OFF_TYPE);
  localparam int BIT_OPER = msb_of(OFF_OPER);
  localparam int BIT_SHA  = msb_of(OFF_SHA);
  localparam int BIT_SPA  = msb_of(OFF_SPA);
  localparam int BIT_THA  = msb_of(OFF_THA);

  typedef enum logic [2:0] {IDLE, TX_W0, TX_W1, WAIT, DONE} tx_state_e;
  typedef enum logic [1:0] {RX_W0, RX_W1, RX_DROP} rx_state_e;

endpackage

// File: rtl/micro_arp_requester_rx_parser.sv
// Watches the RX stream for a two-beat ARP reply addressed to us that answers
// the currently latched target IP; pulses match_o with the sender MAC.
module micro_arp_rx_parser
  import micro_arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02ABCD000102
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] rx_data_i,
  input  logic         rx_valid_i,
  input  logic         rx_sop_i,
  input  logic         rx_eop_i,
  input  logic [4:0]   rx_empty_i,
  input  logic [31:0]  target_ip_i,
  output logic         match_o,
  output logic [47:0]  sha_o
);

  rx_state_e   state_q;
  logic [47:0] sha_cap_q;
  logic [47:0] sha_q;
  logic        match_q;
  logic        hdr_ok;
  logic        tail_ok;
  logic        unused_rx;

  assign hdr_ok = (rx_data_i[BIT_TYPE -: 16] == ETHERTYPE_ARP) &&
                  (rx_data_i[BIT_OPER -: 16] == ARP_OPER_REPLY) &&
                  (rx_data_i[BIT_SPA -: 32] == target_ip_i);
  // beat 1 must actually carry the THA bytes it is being compared on
  assign tail_ok = rx_eop_i && (rx_empty_i <= RX_W1_MAX_EMPTY) &&
                   (rx_data_i[BIT_THA -: 48] == LOCAL_MAC);
  assign unused_rx = ^{rx_data_i[207:160], rx_data_i[143:96]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RX_W0;
      sha_cap_q <= '0;
      sha_q     <= '0;
      match_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (rx_valid_i) begin
        if (rx_sop_i) begin
          sha_cap_q <= rx_data_i[BIT_SHA -: 48];
          if (rx_eop_i)    state_q <= RX_W0;
          else if (hdr_ok) state_q <= RX_W1;
          else             state_q <= RX_DROP;
        end else begin
          case (state_q)
            RX_W1: begin
              if (tail_ok) begin
                match_q <= 1'b1;
                sha_q   <= sha_cap_q;
              end
              state_q <= rx_eop_i ? RX_W0 : RX_DROP;
            end
            RX_DROP: if (rx_eop_i) state_q <= RX_W0;
            default: state_q <= rx_eop_i ? RX_W0 : RX_DROP;
          endcase
        end
      end
    end
  end

  assign match_o = match_q;
  assign sha_o   = sha_q;

endmodule

// File: rtl/micro_arp_requester.sv
// ARP resolver: broadcasts a who-has request for req_ip, waits for the reply,
// retransmits on timeout and reports the resolved MAC or a timeout error.
module micro_arp_requester
  import micro_arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC      = 48'h02ABCD000102,
  parameter logic [31:0] LOCAL_IP       = 32'h0A000014,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_ip,
  output logic         resp_valid,
  output logic [47:0]  resp_mac,
  output logic [31:0]  resp_ip,
  output logic         resp_error,
  output logic [255:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_startofpacket,
  output logic         tx_endofpacket,
  output logic [4:0]   tx_empty,
  input  logic [255:0] rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic         rx_startofpacket,
  input  logic         rx_endofpacket,
  input  logic [4:0]   rx_empty
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [255:0] BEAT0 = {BCAST_MAC, LOCAL_MAC, ETHERTYPE_ARP, HTYPE_ETH,
                                    PTYPE_IPV4, HLEN_ETH, PLEN_IPV4, ARP_OPER_REQ,
                                    LOCAL_MAC, LOCAL_IP};

  tx_state_e      state_q;
  logic [TW-1:0]  tmo_q;
  logic [RW-1:0]  rty_q;
  logic [31:0]    ip_q;
  logic           req_ready_q;
  logic [255:0]   tx_data_q;
  logic           tx_valid_q, tx_sop_q, tx_eop_q;
  logic [4:0]     tx_empty_q;
  logic           resp_valid_q, resp_error_q;
  logic [47:0]    resp_mac_q;
  logic [31:0]    resp_ip_q;
  logic           match;
  logic [47:0]    sha;
  logic [255:0]   beat1_d;

  assign beat1_d = {48'h0, ip_q, 176'h0};

  micro_arp_rx_parser #(.LOCAL_MAC(LOCAL_MAC)) u_rx_parser (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_sop_i    (rx_startofpacket),
    .rx_eop_i    (rx_endofpacket),
    .rx_empty_i  (rx_empty),
    .target_ip_i (ip_q),
    .match_o     (match),
    .sha_o       (sha)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      rty_q        <= '0;
      ip_q         <= '0;
      req_ready_q  <= 1'b1;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_sop_q     <= 1'b0;
      tx_eop_q     <= 1'b0;
      tx_empty_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_mac_q   <= '0;
      resp_ip_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          ip_q        <= req_ip;
          rty_q       <= '0;
          req_ready_q <= 1'b0;
          tx_data_q   <= BEAT0;
          tx_valid_q  <= 1'b1;
          tx_sop_q    <= 1'b1;
          state_q     <= TX_W0;
        end
        TX_W0: if (tx_ready) begin
          tx_data_q  <= beat1_d;
          tx_sop_q   <= 1'b0;
          tx_eop_q   <= 1'b1;
          tx_empty_q <= TX_W1_EMPTY;
          state_q    <= TX_W1;
        end
        TX_W1: if (tx_ready) begin
          tx_data_q  <= '0;
          tx_valid_q <= 1'b0;
          tx_eop_q   <= 1'b0;
          tx_empty_q <= '0;
          tmo_q      <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // a reply landing on the last timeout cycle still wins
          if (match) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_mac_q   <= sha;
            resp_ip_q    <= ip_q;
            state_q      <= DONE;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            if (rty_q < RW'(MAX_RETRIES)) begin
              rty_q      <= rty_q + 1'b1;
              tx_data_q  <= BEAT0;
              tx_valid_q <= 1'b1;
              tx_sop_q   <= 1'b1;
              state_q    <= TX_W0;
            end else begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_mac_q   <= '0;
              resp_ip_q    <= ip_q;
              state_q      <= DONE;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_mac         = resp_mac_q;
  assign resp_ip          = resp_ip_q;
  assign resp_error       = resp_error_q;
  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign tx_startofpacket = tx_sop_q;
  assign tx_endofpacket   = tx_eop_q;
  assign tx_empty         = tx_empty_q;
  assign rx_ready         = 1'b1;

endmodule

// File: tb/tb_micro_arp_requester.sv
// Directed bench for micro_arp_requester: request framing, reply matching,
// retry/timeout, backpressure and asynchronous reset behaviour.
module tb_micro_arp_requester;

  localparam logic [47:0] MAC  = 48'h02ABCD000102;
  localparam logic [31:0] MYIP = 32'h0A000014;
  localparam logic [255:0] EXP_B0 =
    256'hFFFFFFFFFFFF02ABCD00010208060001080006040001_02ABCD0001020A000014;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready;
  logic [31:0]  req_ip;
  logic         resp_valid, resp_error;
  logic [47:0]  resp_mac;
  logic [31:0]  resp_ip;
  logic [255:0] tx_data;
  logic         tx_valid, tx_ready, tx_startofpacket, tx_endofpacket;
  logic [4:0]   tx_empty;
  logic [255:0] rx_data;
  logic         rx_valid, rx_ready, rx_startofpacket, rx_endofpacket;
  logic [4:0]   rx_empty;

  int n_assert = 0;
  int n_fail   = 0;
  int sop_cnt  = 0;
  int resp_cnt = 0;

  logic [255:0] cap_d [4];
  logic         cap_s [4];
  logic         cap_e [4];
  logic [4:0]   cap_m [4];

  micro_arp_requester #(
    .LOCAL_MAC(MAC), .LOCAL_IP(MYIP), .TIMEOUT_CYCLES(20), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ip(req_ip),
    .resp_valid(resp_valid), .resp_mac(resp_mac), .resp_ip(resp_ip), .resp_error(resp_error),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_startofpacket(tx_startofpacket), .tx_endofpacket(tx_endofpacket), .tx_empty(tx_empty),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_startofpacket(rx_startofpacket), .rx_endofpacket(rx_endofpacket), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_valid && tx_ready && tx_startofpacket) sop_cnt++;
    if (resp_valid) resp_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] reply_b0(input logic [47:0] sha, input logic [31:0] spa,
                                            input logic [15:0] etype);
    return {MAC, sha, etype, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, sha, spa};
  endfunction

  task automatic send_req(input logic [31:0] ip);
    @(negedge clk);
    req_valid = 1'b1;
    req_ip    = ip;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] d, input bit s, input bit e, input logic [4:0] emp);
    rx_data = d; rx_startofpacket = s; rx_endofpacket = e; rx_empty = emp; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_startofpacket = 1'b0; rx_endofpacket = 1'b0;
  endtask

  task automatic send_reply(input logic [47:0] sha, input logic [31:0] spa);
    send_beat(reply_b0(sha, spa, 16'h0806), 1'b1, 1'b0, 5'd0);
    send_beat({MAC, MYIP, 176'h0}, 1'b0, 1'b1, 5'd22);
  endtask

  task automatic capture(input bit toggle, output int nb, output int held_bad);
    logic [255:0] prev;
    bit have_prev, done;
    nb = 0; held_bad = 0; have_prev = 0; done = 0; prev = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      tx_ready = toggle ? (i % 2 == 1) : 1'b1;
      if (tx_valid) begin
        if (have_prev && tx_data !== prev) held_bad++;
        if (tx_ready) begin
          if (nb < 4) begin
            cap_d[nb] = tx_data; cap_s[nb] = tx_startofpacket;
            cap_e[nb] = tx_endofpacket; cap_m[nb] = tx_empty;
          end
          nb++;
          have_prev = 0;
          if (tx_endofpacket) done = 1;
        end else begin
          have_prev = 1;
          prev = tx_data;
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
  endtask

  task automatic check_frame(input string pre, input int nb, input logic [31:0] ip);
    chk({pre, "_nbeats"}, nb, 2);
    chk({pre, "_b0_data"}, cap_d[0], EXP_B0);
    chk({pre, "_b0_flags"}, {cap_s[0], cap_e[0], cap_m[0]}, {1'b1, 1'b0, 5'd0});
    chk({pre, "_b1_data"}, cap_d[1], {48'h0, ip, 176'h0});
    chk({pre, "_b1_flags"}, {cap_s[1], cap_e[1], cap_m[1]}, {1'b0, 1'b1, 5'd22});
  endtask

  task automatic wait_resp(input int maxc, output bit seen);
    seen = 0;
    for (int i = 0; i < maxc; i++) begin
      if (resp_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, hb, r0, s0;
    bit seen;
    reset_n = 1'b0; req_valid = 1'b0; req_ip = '0; tx_ready = 1'b0;
    rx_data = '0; rx_valid = 1'b0; rx_startofpacket = 1'b0; rx_endofpacket = 1'b0; rx_empty = '0;

    repeat (2) @(negedge clk);
    chk("reset_ctrl", {tx_valid, tx_startofpacket, tx_endofpacket, tx_empty, resp_valid,
                       resp_error, req_ready, rx_ready}, {1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    chk("reset_data", {tx_data, resp_mac, resp_ip} , '0);
    reset_n = 1'b1;
    @(negedge clk);

    // basic request frame, no backpressure
    tx_ready = 1'b1;
    send_req(32'h0A00000A);
    chk("req_ready_busy", req_ready, 1'b0);
    capture(1'b0, nb, hb);
    check_frame("frame", nb, 32'h0A00000A);

    // reply 10 cycles into WAIT
    repeat (10) @(negedge clk);
    send_reply(48'h3CFDFEA67500, 32'h0A00000A);
    wait_resp(10, seen);
    chk("reply_seen", seen, 1'b1);
    chk("reply_fields", {resp_mac, resp_error, resp_ip}, {48'h3CFDFEA67500, 1'b0, 32'h0A00000A});
    @(negedge clk);
    chk("reply_pulse_ready", {resp_valid, req_ready}, {1'b0, 1'b1});

    // a matching reply while IDLE must be ignored
    r0 = resp_cnt;
    send_reply(48'h3CFDFEA67500, 32'h0A00000A);
    repeat (4) @(negedge clk);
    chk("idle_reply_ignored", resp_cnt, r0);

    // backpressure: ready toggling on alternate cycles
    send_req(32'h0A00000A);
    capture(1'b1, nb, hb);
    check_frame("bp", nb, 32'h0A00000A);
    chk("bp_held_stable", hb, 0);
    send_reply(48'h3CFDFEA67500, 32'h0A00000A);
    wait_resp(10, seen);
    chk("bp_reply_seen", seen, 1'b1);
    @(negedge clk);

    // wrong SPA, 3-beat non-ARP, orphan beat 0, then the good reply
    r0 = resp_cnt;
    send_req(32'h0A00000A);
    capture(1'b0, nb, hb);
    send_reply(48'h111111111111, 32'h0A00000B);
    send_beat(reply_b0(48'h222222222222, 32'h0A00000A, 16'h0800), 1'b1, 1'b0, 5'd0);
    send_beat({MAC, MYIP, 176'h0}, 1'b0, 1'b0, 5'd0);
    send_beat({MAC, MYIP, 176'h0}, 1'b0, 1'b1, 5'd22);
    send_beat(reply_b0(48'hAABBCCDDEEFF, 32'h0A00000A, 16'h0806), 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    chk("filter_no_resp", {resp_valid, 32'(resp_cnt)}, {1'b0, 32'(r0)});
    send_reply(48'h001122334455, 32'h0A00000A);
    wait_resp(10, seen);
    chk("filter_good_seen", seen, 1'b1);
    chk("filter_good_mac", {resp_mac, resp_error}, {48'h001122334455, 1'b0});
    @(negedge clk);

    // no reply: first attempt + 2 retries, then timeout error
    s0 = sop_cnt;
    send_req(32'h0A000063);
    wait_resp(300, seen);
    chk("timeout_seen", seen, 1'b1);
    chk("timeout_frames", sop_cnt - s0, 3);
    chk("timeout_fields", {resp_mac, resp_error, resp_ip}, {48'h0, 1'b1, 32'h0A000063});
    @(negedge clk);
    chk("timeout_pulse", resp_valid, 1'b0);

    // asynchronous reset while a beat is being held
    tx_ready = 1'b0;
    send_req(32'h0A000077);
    chk("pre_reset_txvalid", {tx_valid, tx_startofpacket}, {1'b1, 1'b1});
    reset_n = 1'b0;
    #1;
    chk("rst_tx_immediate", {tx_valid, tx_startofpacket, tx_data}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tx_ready = 1'b1;

    // reset in WAIT abandons the request silently
    send_req(32'h0A000077);
    repeat (6) @(negedge clk);
    r0 = resp_cnt;
    s0 = sop_cnt;
    reset_n = 1'b0;
    #1;
    chk("rst_wait_immediate", {tx_valid, resp_valid, resp_error, req_ready, rx_ready},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", req_ready, 1'b1);
    repeat (40) @(negedge clk);
    chk("rst_no_resp_no_tx", {32'(resp_cnt), 32'(sop_cnt)}, {32'(r0), 32'(s0)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
